// File: rtl/antirrebote_pulso.sv
// Push-button conditioner: two-flop synchroniser, stability-counter
// debounce FSM, one-cycle pulse per confirmed press and debounced level.
module antirrebote_pulso #(
    parameter int N_ESTABLE = 4
) (
    input  logic clk,
    input  logic reset_n_i,
    input  logic boton_i,
    output logic pulso_o,
    output logic estado_o
);

    // Counter width is derived from N_ESTABLE and must not be set separately.
    localparam int ANCHO_CNT = $clog2(N_ESTABLE) + 1;
    localparam logic [ANCHO_CNT-1:0] CNT_MAX = ANCHO_CNT'(N_ESTABLE - 1);
    localparam logic [ANCHO_CNT-1:0] CNT_UNO = ANCHO_CNT'(1);

    typedef enum logic [1:0] {
        SUELTO         = 2'd0,
        ESPERA_PRESION = 2'd1,
        PRESIONADO     = 2'd2,
        ESPERA_SUELTA  = 2'd3
    } estado_t;

    logic                 s1_reg;
    logic                 s2_reg;
    logic                 boton_s;
    estado_t              state_reg;
    estado_t              state_next;
    logic [ANCHO_CNT-1:0] cnt_reg;
    logic [ANCHO_CNT-1:0] cnt_next;
    logic                 pulso_reg;
    logic                 pulso_next;
    logic                 estado_reg;
    logic                 estado_next;

    // Bring the asynchronous button level into the clk domain.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            s1_reg <= 1'b0;
            s2_reg <= 1'b0;
        end else begin
            s1_reg <= boton_i;
            s2_reg <= s1_reg;
        end
    end

    assign boton_s = s2_reg;

    // FSM state, stability counter and registered outputs.
    always_ff @(posedge clk or negedge reset_n_i) begin
        if (!reset_n_i) begin
            state_reg  <= SUELTO;
            cnt_reg    <= '0;
            pulso_reg  <= 1'b0;
            estado_reg <= 1'b0;
        end else begin
            state_reg  <= state_next;
            cnt_reg    <= cnt_next;
            pulso_reg  <= pulso_next;
            estado_reg <= estado_next;
        end
    end

    // Next-state logic: the counter only advances inside the wait states and
    // is otherwise forced to 0, so reaching CNT_MAX always leaves the state.
    always_comb begin
        state_next = state_reg;
        cnt_next   = '0;
        pulso_next = 1'b0;
        case (state_reg)
            SUELTO: begin
                if (boton_s) begin
                    state_next = ESPERA_PRESION;
                end
            end
            ESPERA_PRESION: begin
                if (!boton_s) begin
                    state_next = SUELTO;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = PRESIONADO;
                    pulso_next = 1'b1;
                end else begin
                    cnt_next = cnt_reg + CNT_UNO;
                end
            end
            PRESIONADO: begin
                if (!boton_s) begin
                    state_next = ESPERA_SUELTA;
                end
            end
            ESPERA_SUELTA: begin
                if (boton_s) begin
                    state_next = PRESIONADO;
                end else if (cnt_reg == CNT_MAX) begin
                    state_next = SUELTO;
                end else begin
                    cnt_next = cnt_reg + CNT_UNO;
                end
            end
            default: begin
                state_next = SUELTO;
            end
        endcase
        // Debounced level is high while the press stands or its release is pending.
        estado_next = (state_next == PRESIONADO) || (state_next == ESPERA_SUELTA);
    end

    assign pulso_o  = pulso_reg;
    assign estado_o = estado_reg;

endmodule
